// File: rtl/door_controller.sv
// door_controller: Moore FSM sequencing the elevator car door.
// Opens on arrival, holds open, closes, reopens on obstruction.
// Also provides the motion interlock and latches actuator/sensor faults.
// The cycle counter `cnt` is shared by the hold timer and the travel timeout.
module door_controller #(
    parameter int HOLD_CYCLES = 1000,
    parameter int MOVE_LIMIT  = 200,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       open_req,
    input  logic       at_floor,
    input  logic       btn_open,
    input  logic       btn_close,
    input  logic       obstacle,
    input  logic       sens_open,
    input  logic       sens_closed,
    output logic       motor_open,
    output logic       motor_close,
    output logic [1:0] estado,
    output logic       door_closed_ok,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_FAULT
    } state_t;

    // Counter values at which the hold timer and the travel timeout expire.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             retrigger;
    logic             sens_conflict;
    logic             reopen_cause;

    // Both limit switches active at once means a broken sensor or wiring.
    assign sens_conflict = sens_open & sens_closed;

    // Anything that should keep the door open or push it back open.
    assign reopen_cause = obstacle | btn_open;

    // Next-state selection; retrigger restarts the hold timer while staying in OPEN.
    always_comb begin
        state_nxt = state;
        retrigger = 1'b0;
        if ((state != ST_FAULT) && sens_conflict) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_CLOSED: begin
                    if (open_req || (btn_open && at_floor)) begin
                        state_nxt = ST_OPENING;
                    end else if (!sens_closed) begin
                        state_nxt = ST_CLOSING;
                    end
                end
                ST_OPENING: begin
                    if (sens_open) begin
                        state_nxt = ST_OPEN;
                    end else if (cnt == MOVE_LAST) begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_OPEN: begin
                    if (reopen_cause) begin
                        retrigger = 1'b1;
                    end else if (btn_close) begin
                        state_nxt = ST_CLOSING;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    if (reopen_cause) begin
                        state_nxt = ST_OPENING;
                    end else if (sens_closed) begin
                        state_nxt = ST_CLOSED;
                    end else if (cnt == MOVE_LAST) begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_FAULT;
                end
            endcase
        end
    end

    // State, shared counter and Moore outputs, all registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_CLOSED;
            cnt            <= '0;
            motor_open     <= 1'b0;
            motor_close    <= 1'b0;
            estado         <= 2'b00;
            door_closed_ok <= 1'b1;
            fault          <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || retrigger) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            case (state_nxt)
                ST_CLOSED: begin
                    motor_open     <= 1'b0;
                    motor_close    <= 1'b0;
                    estado         <= 2'b00;
                    door_closed_ok <= 1'b1;
                    fault          <= 1'b0;
                end
                ST_OPENING: begin
                    motor_open     <= 1'b1;
                    motor_close    <= 1'b0;
                    estado         <= 2'b10;
                    door_closed_ok <= 1'b0;
                    fault          <= 1'b0;
                end
                ST_OPEN: begin
                    motor_open     <= 1'b0;
                    motor_close    <= 1'b0;
                    estado         <= 2'b01;
                    door_closed_ok <= 1'b0;
                    fault          <= 1'b0;
                end
                ST_CLOSING: begin
                    motor_open     <= 1'b0;
                    motor_close    <= 1'b1;
                    estado         <= 2'b11;
                    door_closed_ok <= 1'b0;
                    fault          <= 1'b0;
                end
                default: begin
                    motor_open     <= 1'b0;
                    motor_close    <= 1'b0;
                    estado         <= 2'b00;
                    door_closed_ok <= 1'b0;
                    fault          <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_controller.sv
// tb_door_controller: directed scenarios plus randomized traffic for door_controller,
// compared cycle by cycle against a behavioural model of the door rules.
module tb_door_controller;

    localparam int HOLD = 8;
    localparam int MOVE = 5;
    localparam int CW   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       open_req;
    logic       at_floor;
    logic       btn_open;
    logic       btn_close;
    logic       obstacle;
    logic       sens_open;
    logic       sens_closed;
    logic       motor_open;
    logic       motor_close;
    logic [1:0] estado;
    logic       door_closed_ok;
    logic       fault;

    typedef enum {DOOR_SHUT, DOOR_OPENING, DOOR_HELD, DOOR_SHUTTING, DOOR_BROKEN} door_t;

    door_t m_phase;
    int    m_age;
    int    total_count;
    int    bad_count;
    int    pos;
    int    open_cycles;
    int    broken_time;
    int    stuck_time;

    door_controller #(
        .HOLD_CYCLES (HOLD),
        .MOVE_LIMIT  (MOVE),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .open_req       (open_req),
        .at_floor       (at_floor),
        .btn_open       (btn_open),
        .btn_close      (btn_close),
        .obstacle       (obstacle),
        .sens_open      (sens_open),
        .sens_closed    (sens_closed),
        .motor_open     (motor_open),
        .motor_close    (motor_close),
        .estado         (estado),
        .door_closed_ok (door_closed_ok),
        .fault          (fault)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_count++;
        if (got !== want) begin
            bad_count++;
            $display("[TB] FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [5:0] observed();
        return {motor_open, motor_close, estado, door_closed_ok, fault};
    endfunction

    // Expected {motor_open, motor_close, estado, door_closed_ok, fault} per door phase.
    function automatic logic [5:0] modelOutputs();
        case (m_phase)
            DOOR_SHUT:     return 6'b00_00_1_0;
            DOOR_OPENING:  return 6'b10_10_0_0;
            DOOR_HELD:     return 6'b00_01_0_0;
            DOOR_SHUTTING: return 6'b01_11_0_0;
            default:       return 6'b00_00_0_1;
        endcase
    endfunction

    // Advance the model by one clock using the inputs sampled at this edge.
    task automatic modelUpdate();
        door_t nxt;
        bit    rearm;
        nxt   = m_phase;
        rearm = 1'b0;
        if (!rst_n) begin
            m_phase = DOOR_SHUT;
            m_age   = 0;
        end else begin
            if (m_phase != DOOR_BROKEN && sens_open && sens_closed) begin
                nxt = DOOR_BROKEN;
            end else begin
                case (m_phase)
                    DOOR_SHUT:
                        if (open_req || (btn_open && at_floor)) nxt = DOOR_OPENING;
                        else if (!sens_closed) nxt = DOOR_SHUTTING;
                    DOOR_OPENING:
                        if (sens_open) nxt = DOOR_HELD;
                        else if (m_age + 1 >= MOVE) nxt = DOOR_BROKEN;
                    DOOR_HELD:
                        if (obstacle || btn_open) rearm = 1'b1;
                        else if (btn_close || m_age + 1 >= HOLD) nxt = DOOR_SHUTTING;
                    DOOR_SHUTTING:
                        if (obstacle || btn_open) nxt = DOOR_OPENING;
                        else if (sens_closed) nxt = DOOR_SHUT;
                        else if (m_age + 1 >= MOVE) nxt = DOOR_BROKEN;
                    default: nxt = DOOR_BROKEN;
                endcase
            end
            m_age   = (nxt != m_phase || rearm) ? 0 : m_age + 1;
            m_phase = nxt;
        end
    endtask

    // One clock: model follows the edge, DUT outputs are compared 1 time unit later.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput(tag, {26'd0, observed()}, {26'd0, modelOutputs()});
        checkOutput({tag, "_excl"}, {31'd0, motor_open & motor_close}, 32'd0);
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        m_phase     = DOOR_SHUT;
        m_age       = 0;
        rst_n       = 1'b0;
        open_req    = 1'b0;
        at_floor    = 1'b1;
        btn_open    = 1'b0;
        btn_close   = 1'b0;
        obstacle    = 1'b0;
        sens_open   = 1'b0;
        sens_closed = 1'b1;

        // Reset and normal open/hold/close cycle.
        applyStimulus("reset");
        applyStimulus("reset");
        checkOutput("reset_outs", {26'd0, observed()}, {26'd0, 6'b00_00_1_0});
        rst_n = 1'b1;
        applyStimulus("idle");
        open_req = 1'b1;
        applyStimulus("open_req");
        checkOutput("opening_outs", {26'd0, observed()}, {26'd0, 6'b10_10_0_0});
        open_req    = 1'b0;
        sens_closed = 1'b0;
        applyStimulus("opening");
        applyStimulus("opening");
        sens_open = 1'b1;
        applyStimulus("reach_open");
        sens_open   = 1'b0;
        open_cycles = (estado == 2'b01) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus("hold");
            if (estado != 2'b01) break;
            open_cycles++;
        end
        checkOutput("hold_len", open_cycles, HOLD);
        checkOutput("closing_estado", {30'd0, estado}, 32'd3);
        applyStimulus("closing");
        sens_closed = 1'b1;
        applyStimulus("reach_closed");
        checkOutput("closed_again", {26'd0, observed()}, {26'd0, 6'b00_00_1_0});

        // Retrigger by btn_open and obstacle while open.
        open_req = 1'b1;
        applyStimulus("open_req2");
        open_req    = 1'b0;
        sens_closed = 1'b0;
        sens_open   = 1'b1;
        applyStimulus("reach_open2");
        sens_open = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus("hold2");
        btn_open = 1'b1;
        applyStimulus("retrig_btn");
        btn_open = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus("hold3");
        obstacle = 1'b1;
        applyStimulus("retrig_obs");
        obstacle = 1'b0;
        for (int i = 0; i < 12 && estado == 2'b01; i++) applyStimulus("hold4");
        checkOutput("retrig_close", {30'd0, estado}, 32'd3);

        // Obstacle together with sens_closed reopens instead of closing.
        obstacle    = 1'b1;
        sens_closed = 1'b1;
        applyStimulus("reopen");
        checkOutput("reopen_outs", {26'd0, observed()}, {26'd0, 6'b10_10_0_0});
        obstacle    = 1'b0;
        sens_closed = 1'b0;
        sens_open   = 1'b1;
        applyStimulus("reach_open3");
        sens_open = 1'b0;

        // btn_close loses to obstacle; then a sensor conflict faults.
        btn_close = 1'b1;
        obstacle  = 1'b1;
        applyStimulus("close_vs_obs");
        checkOutput("stay_open", {30'd0, estado}, 32'd1);
        btn_close   = 1'b0;
        obstacle    = 1'b0;
        sens_open   = 1'b1;
        sens_closed = 1'b1;
        applyStimulus("conflict");
        checkOutput("conflict_fault", {26'd0, observed()}, {26'd0, 6'b00_00_0_1});
        sens_open = 1'b0;
        open_req  = 1'b1;
        applyStimulus("fault_sticky");
        open_req = 1'b0;

        // Actuator timeout while opening.
        rst_n = 1'b0;
        applyStimulus("reset2");
        rst_n    = 1'b1;
        open_req = 1'b1;
        applyStimulus("open_req3");
        open_req    = 1'b0;
        sens_closed = 1'b0;
        for (int i = 0; i < MOVE - 1; i++) applyStimulus("stall");
        checkOutput("still_opening", {30'd0, estado}, 32'd2);
        applyStimulus("timeout");
        checkOutput("timeout_fault", {26'd0, observed()}, {26'd0, 6'b00_00_0_1});
        open_req = 1'b1;
        applyStimulus("fault_hold");
        open_req = 1'b0;
        checkOutput("fault_kept", {31'd0, fault}, 32'd1);

        // Reset with the door ajar, then reset during closing.
        rst_n = 1'b0;
        applyStimulus("reset_ajar");
        rst_n = 1'b1;
        applyStimulus("ajar_close");
        rst_n = 1'b0;
        applyStimulus("reset_closing");
        checkOutput("reset_dco", {31'd0, door_closed_ok}, 32'd1);
        rst_n = 1'b1;
        applyStimulus("reclose");
        checkOutput("reclose_estado", {30'd0, estado}, 32'd3);

        // Randomized traffic driven through a simple door position model.
        pos         = 1;
        broken_time = 0;
        stuck_time  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_phase == DOOR_OPENING && pos < 3 && $urandom_range(1, 0) == 1) pos++;
            if (m_phase == DOOR_SHUTTING && pos > 0 && $urandom_range(1, 0) == 1) pos--;
            broken_time = (m_phase == DOOR_BROKEN) ? broken_time + 1 : 0;
            if (stuck_time > 0) stuck_time--;
            else if ($urandom_range(150, 0) == 0) stuck_time = 10;
            rst_n       = !((broken_time > 6) || ($urandom_range(120, 0) == 0));
            open_req    = (m_phase == DOOR_SHUT) && ($urandom_range(15, 0) == 0);
            at_floor    = $urandom_range(4, 0) != 0;
            btn_open    = $urandom_range(30, 0) == 0;
            btn_close   = $urandom_range(12, 0) == 0;
            obstacle    = $urandom_range(25, 0) == 0;
            sens_open   = (pos == 3) && (stuck_time == 0);
            sens_closed = (pos == 0) && (stuck_time == 0);
            if ($urandom_range(300, 0) == 0) begin
                sens_open   = 1'b1;
                sens_closed = 1'b1;
            end
            applyStimulus("random");
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
